imem_fetch_sequencer: RTL
=========================

// Module: imem_fetch_sequencer
// PURPOSE
//  Drives instruction_memory's combinational read port: holds the program counter (PC), fetches one
//  instruction slot per accepted transfer and hands instructions to decode over a valid/ready handshake.
//  Applies branch redirects from execute, stops on hlt and flags PC overruns.
//  Sits between instruction_memory and the SimpleRISC decode stage.
// PARAMETERS
//  RESET_PC  0    first fetch address after reset or start
//  STRIDE    4    PC increment per instruction (program slots are 4 words apart; padding words are never fetched)
//  DEPTH     256  imem entries; any PC >= DEPTH is an overrun
// PORTS
//  clk         in   1   clock; all state updates on its rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   1-cycle pulse; begins (or restarts) execution at RESET_PC
//  imem_addr   out  32  read address to instruction_memory; always equals pc
//  imem_instr  in   32  instruction_memory data; combinational from imem_addr
//  inst_out    out  32  instruction presented to decode
//  inst_pc     out  32  address inst_out was fetched from
//  inst_valid  out  1   inst_out/inst_pc are valid
//  inst_ready  in   1   decode accepts when inst_valid && inst_ready
//  br_taken    in   1   redirect request from execute, 1-cycle pulse
//  br_target   in   32  absolute target address, sampled with br_taken
//  busy        out  1   state is RUN
//  halted      out  1   state is HALT
//  fault       out  1   sticky; PC overrun detected
// BEHAVIOUR
//  Reset:
//   - pc=RESET_PC, state=IDLE; inst_out=0, inst_pc=0, inst_valid=0, fault=0.
//   - Reset takes priority over every other input, including mid-run.
//  FSM states: IDLE, RUN, HALT.
//   - IDLE: nothing is fetched. start -> RUN.
//   - RUN:
//     - Define free = !inst_valid || inst_ready.
//     - Capture: when free, register inst_out<=imem_instr, inst_pc<=pc, inst_valid<=1, pc<=pc+STRIDE.
//     - Drain: when inst_valid && inst_ready and no capture occurs that cycle, inst_valid<=0.
//     - Stall: when inst_valid && !inst_ready, every output and pc hold.
//     - Latency: instruction at pc is on inst_out 1 cycle after capture. Throughput is 1 instruction/cycle.
//   - HALT: no fetch. inst_valid keeps its value until decode accepts, then drops to 0.
//  Redirect (br_taken=1, in RUN or HALT):
//   - pc<=br_target, inst_valid<=0 (buffered instruction is flushed), no capture that cycle, state<=RUN.
//   - Overrides capture, drain, halt detection and overrun checking in the same cycle.
//   - A redirect in HALT covers the case where a branch older than hlt resolves after hlt was fetched.
//   - fault is not cleared by a redirect.
//  Halt detection:
//   - A capture with imem_instr[31:27]==5'b11111 (hlt) still captures normally (hlt reaches decode).
//   - pc still advances by STRIDE; then state<=HALT.
//  nop (opcode 5'b01101) gets no special handling; it is passed through like any instruction.
//  Overrun check (applies in RUN only, to the capture condition):
//   - If pc >= DEPTH when a capture would occur: no capture, fault<=1, state<=HALT, pc holds.
//   - fault is cleared only by reset or start.
//  start:
//   - In any state: pc<=RESET_PC, inst_valid<=0, fault<=0, state<=RUN.
//   - If br_taken is also 1 in that cycle, start wins.
//  br_taken in IDLE is ignored.
//  Width rules:
//   - pc+STRIDE is computed modulo 2^32; wrap is caught by the DEPTH check, never silently reused.
//   - br_target is used as given; alignment to STRIDE is not checked.
// TESTING
//  1 reset, start, inst_ready=1, stock program -> inst_pc = 0,4,8,... one per cycle; hlt at 72 presented, then halted=1.
//  2 inst_ready=0 for 3 cycles while inst_valid=1 at pc 16 -> inst_out/inst_pc/imem_addr frozen; resume 20 with no loss or duplicate.
//  3 br_taken=1, br_target=72, on cycle inst_pc=24 valid -> 24 flushed, next inst_pc=72, halted after hlt accepted.
//  4 hlt fetched, then br_taken target=36 in HALT -> state RUN, inst_pc sequence 36,40,...; halted=0.
//  5 br_target=252, ready=1 -> 252 presented, then pc=256 -> fault=1, halted=1, no capture at 256; start clears fault.
//  6 reset asserted mid-RUN with inst_valid=1 -> next cycle inst_valid=0, pc=0, IDLE, busy=0; br_taken ignored until start.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter, reads one program
// slot per accepted transfer from a combinational instruction memory and
// presents it to decode over a valid/ready handshake. Handles branch
// redirects, halts on hlt and flags PC overruns with a sticky fault.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] STRIDE   = 32'd4,
  parameter int unsigned DEPTH    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        busy,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [4:0]  OP_HLT  = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
  logic        busy_q, halted_q;

  // The output slot can take a new instruction when it is empty or being
  // consumed this cycle.
  logic free;
  logic accept;
  logic overrun;

  assign free    = !inst_valid_q || inst_ready;
  assign accept  = inst_valid_q && inst_ready;
  // Wrap of pc+STRIDE past 2^32 lands at a small address only after passing
  // through DEPTH, so this compare catches every runaway PC.
  assign overrun = (pc_q >= DEPTH_W);

  // Next-state selection: start beats redirect, redirect beats everything
  // the RUN/HALT states would otherwise do.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;

    if (start) begin
      pc_d         = RESET_PC;
      inst_valid_d = 1'b0;
      fault_d      = 1'b0;
      state_d      = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Redirects are meaningless before execution starts.
        end
        S_RUN: begin
          if (br_taken) begin
            pc_d         = br_target;
            inst_valid_d = 1'b0;
          end else if (free) begin
            if (overrun) begin
              // Refuse to fetch out of range; the slot still drains.
              fault_d      = 1'b1;
              inst_valid_d = 1'b0;
              state_d      = S_HALT;
            end else begin
              inst_out_d   = imem_instr;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + STRIDE;
              if (imem_instr[31:27] == OP_HLT) begin
                state_d = S_HALT;
              end
            end
          end
        end
        S_HALT: begin
          if (br_taken) begin
            // A branch older than the hlt resolved late: resume fetching.
            pc_d         = br_target;
            inst_valid_d = 1'b0;
            state_d      = S_RUN;
          end else if (accept) begin
            inst_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_out_q   <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      busy_q       <= (state_d == S_RUN);
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign imem_addr  = pc_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
